// File: rtl/window_feeder.sv
// window_feeder: turns a raster-order pixel stream into KxK windows for a compute stage.
// Each complete window is handed over with a start pulse; the stream stalls until the
// compute stage answers with done, then the registered result is emitted with clear.
// Assumes MAX_KERNEL >= 2 and img_width <= IMG_W_MAX, img_height <= IMG_H_MAX.
module window_feeder #(
   parameter int unsigned MAX_KERNEL = 3,
   parameter int unsigned IMG_W_MAX  = 64,
   parameter int unsigned IMG_H_MAX  = 64
) (
   input  logic                                       clk,
   input  logic                                       n_rst,
   input  logic                                       frame_start,
   input  logic [$clog2(IMG_W_MAX+1)-1:0]             img_width,
   input  logic [$clog2(IMG_H_MAX+1)-1:0]             img_height,
   input  logic                                       in_valid,
   input  logic [7:0]                                 in_pixel,
   output logic                                       in_ready,
   output logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] window,
   output logic                                       start,
   input  logic                                       done,
   input  logic [7:0]                                 result,
   output logic                                       clear,
   output logic                                       out_valid,
   output logic [7:0]                                 out_pixel,
   output logic                                       frame_done
);

   localparam int unsigned K  = MAX_KERNEL;
   localparam int unsigned WW = $clog2(IMG_W_MAX + 1);
   localparam int unsigned HW = $clog2(IMG_H_MAX + 1);
   localparam int unsigned AW = (IMG_W_MAX > 1) ? $clog2(IMG_W_MAX) : 1;

   localparam logic [WW-1:0] COL_MIN = WW'(K - 1);
   localparam logic [HW-1:0] ROW_MIN = HW'(K - 1);
   localparam logic [WW-1:0] COL_ONE = WW'(1);
   localparam logic [HW-1:0] ROW_ONE = HW'(1);

   typedef enum logic [2:0] {
      StIdle,
      StAccept,
      StIssue,
      StWait,
      StClear,
      StFin
   } state_e;

   state_e                   state_q, state_d;
   logic [WW-1:0]            width_q, width_d;
   logic [HW-1:0]            height_q, height_d;
   logic [WW-1:0]            col_q, col_d;
   logic [HW-1:0]            row_q, row_d;
   logic                     last_q, last_d;
   logic [7:0]               out_pixel_q, out_pixel_d;
   logic [K-1:0][K-1:0][7:0] window_q, window_d;

   // lb_q[0] holds the oldest buffered row, lb_q[K-2] the row just above the input row.
   logic [7:0]               lb_q [K-1][IMG_W_MAX];

   logic [K-1:0][7:0]        col_new;
   logic [AW-1:0]            col_idx;
   logic                     accept;
   logic                     col_end;
   logic                     row_end;
   logic                     win_ready;

   assign col_idx   = col_q[AW-1:0];
   assign accept    = (state_q == StAccept) && in_valid;
   assign col_end   = (col_q == (width_q - COL_ONE));
   assign row_end   = (row_q == (height_q - ROW_ONE));
   // Both bounds must hold so only columns of the current row sit in the window.
   assign win_ready = (row_q >= ROW_MIN) && (col_q >= COL_MIN);

   // Incoming column: buffered pixels above this position, newest pixel at the bottom.
   always_comb begin
      col_new = '0;
      for (int r = 0; r < K - 1; r++) begin
         col_new[r] = lb_q[r][col_idx];
      end
      col_new[K-1] = in_pixel;
   end

   // Next-state, counter, window and result-register update.
   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      col_d       = col_q;
      row_d       = row_q;
      last_d      = last_q;
      out_pixel_d = out_pixel_q;
      window_d    = window_q;

      unique case (state_q)
         StIdle: begin
            if (frame_start) begin
               width_d  = img_width;
               height_d = img_height;
               col_d    = '0;
               row_d    = '0;
               last_d   = 1'b0;
               if ((img_width == '0) || (img_height == '0)) begin
                  state_d = StFin;
               end else begin
                  state_d = StAccept;
               end
            end
         end
         StAccept: begin
            if (accept) begin
               for (int r = 0; r < K; r++) begin
                  for (int c = 0; c < K - 1; c++) begin
                     window_d[r][c] = window_q[r][c+1];
                  end
                  window_d[r][K-1] = col_new[r];
               end
               if (col_end) begin
                  col_d = '0;
                  row_d = row_q + ROW_ONE;
               end else begin
                  col_d = col_q + COL_ONE;
               end
               last_d = row_end && col_end;
               if (win_ready) begin
                  state_d = StIssue;
               end else if (row_end && col_end) begin
                  state_d = StFin;
               end
            end
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (done) begin
               out_pixel_d = result;
               state_d     = StClear;
            end
         end
         StClear: begin
            state_d = last_q ? StFin : StAccept;
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Output decode: every handshake/pulse is a pure function of the current state.
   always_comb begin
      in_ready   = (state_q == StAccept);
      start      = (state_q == StIssue);
      clear      = (state_q == StClear);
      out_valid  = (state_q == StClear);
      frame_done = (state_q == StFin);
      window     = window_q;
      out_pixel  = out_pixel_q;
   end

   // Control and datapath registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= StIdle;
         width_q     <= '0;
         height_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         last_q      <= 1'b0;
         out_pixel_q <= '0;
         window_q    <= '0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         col_q       <= col_d;
         row_q       <= row_d;
         last_q      <= last_d;
         out_pixel_q <= out_pixel_d;
         window_q    <= window_d;
      end
   end

   // Line buffers shift up by one row at the accepted column; contents need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < K - 1; i++) begin
            lb_q[i][col_idx] <= col_new[i+1];
         end
      end
   end

endmodule

// File: tb/tb_window_feeder.sv
// tb_window_feeder: table of frame scenarios plus hand-built reset and frame_start corner cases.
// Expected windows and results are queued when stimulus is driven and popped when the DUT
// raises start / out_valid.
module tb_window_feeder;

   localparam int K  = 3;
   localparam int WW = $clog2(64 + 1);
   localparam int HW = $clog2(64 + 1);

   typedef logic [K-1:0][K-1:0][7:0] win_t;

   typedef struct {
      int         w;
      int         h;
      int         base;
      bit         toggle;
      bit         spur;
      int         dly;
      logic [7:0] res;
      int         exp_starts;
      int         exp_acc;
   } frame_vec_t;

   logic          clk;
   logic          n_rst;
   logic          frame_start;
   logic [WW-1:0] img_width;
   logic [HW-1:0] img_height;
   logic          in_valid;
   logic [7:0]    in_pixel;
   logic          in_ready;
   win_t          window;
   logic          start;
   logic          done;
   logic [7:0]    result;
   logic          clear;
   logic          out_valid;
   logic [7:0]    out_pixel;
   logic          frame_done;

   window_feeder #(
      .MAX_KERNEL (K),
      .IMG_W_MAX  (64),
      .IMG_H_MAX  (64)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .frame_start (frame_start),
      .img_width   (img_width),
      .img_height  (img_height),
      .in_valid    (in_valid),
      .in_pixel    (in_pixel),
      .in_ready    (in_ready),
      .window      (window),
      .start       (start),
      .done        (done),
      .result      (result),
      .clear       (clear),
      .out_valid   (out_valid),
      .out_pixel   (out_pixel),
      .frame_done  (frame_done)
   );

   win_t       exp_win[$];
   logic [7:0] exp_res[$];
   win_t       last_win;
   int         n_vec, n_err;
   int         n_acc, n_start, n_ov, n_fdone;
   int         cyc, done_cyc;
   int         stub_dly;
   logic [7:0] stub_res;
   bit         spur_en;
   bit         abort;
   frame_vec_t tbl[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic win_t exp_window(input int base, input int w, input int r, input int c);
      win_t x;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            x[i][j] = 8'(base + (r - K + 1 + i) * w + (c - K + 1 + j));
         end
      end
      return x;
   endfunction

   // Compute-stage stub: answers each start after stub_dly cycles; optionally fires
   // spurious done pulses while the block is accepting pixels.
   initial begin
      int  cnt;
      bit  ph;
      cnt    = 0;
      ph     = 1'b0;
      done   = 1'b0;
      result = 8'h00;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (!n_rst) begin
            cnt = 0;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               done     = 1'b1;
               result   = stub_res;
               done_cyc = cyc;
               exp_res.push_back(stub_res);
            end
         end else if (start) begin
            cnt = stub_dly;
         end else if (spur_en && in_ready && ph) begin
            done   = 1'b1;
            result = 8'hEE;
         end
         ph = ~ph;
      end
   end

   // Monitor: scoreboard pops and event counts.
   initial begin
      forever begin
         @(negedge clk);
         if (n_rst) begin
            if (in_valid && in_ready) n_acc++;
            if (start) begin
               n_start++;
               check("start has pending window", 128'(exp_win.size() != 0), 128'(1));
               if (exp_win.size() != 0) begin
                  last_win = exp_win.pop_front();
                  check("window at start", window, last_win);
               end
            end
            if (out_valid) begin
               n_ov++;
               check("out_valid has pending result", 128'(exp_res.size() != 0), 128'(1));
               if (exp_res.size() != 0) begin
                  check("out_pixel", out_pixel, exp_res.pop_front());
               end
               check("clear with out_valid", clear, 1'b1);
               check("out_valid one cycle after done", cyc, done_cyc + 1);
               check("window held through wait", window, last_win);
            end
            if (frame_done) n_fdone++;
         end
      end
   end

   task automatic drive_frame(input frame_vec_t v, input string tag);
      int idx, guard, r, c;
      bit ph, acc;
      idx   = 0;
      guard = 0;
      ph    = 1'b1;
      @(posedge clk);
      #1;
      img_width   = WW'(v.w);
      img_height  = HW'(v.h);
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      // Mid-frame size changes must be ignored.
      img_width   = WW'(3);
      img_height  = HW'(2);
      while (idx < v.w * v.h && !abort && guard < 3000) begin
         in_valid = v.toggle ? ph : 1'b1;
         ph       = ~ph;
         in_pixel = in_valid ? 8'(v.base + idx) : 8'hFF;
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc) begin
            r = idx / v.w;
            c = idx % v.w;
            if (r >= K - 1 && c >= K - 1) exp_win.push_back(exp_window(v.base, v.w, r, c));
            idx++;
         end
         @(posedge clk);
         #1;
         guard++;
      end
      in_valid = 1'b0;
      if (!abort) check({tag, " all pixels accepted"}, idx, v.w * v.h);
   endtask

   task automatic run_frame(input frame_vec_t v, input string tag);
      int s0, a0, f0, o0, t;
      s0       = n_start;
      a0       = n_acc;
      f0       = n_fdone;
      o0       = n_ov;
      t        = 0;
      stub_dly = v.dly;
      stub_res = v.res;
      spur_en  = v.spur;
      drive_frame(v, tag);
      while (n_fdone == f0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      repeat (6) @(posedge clk);
      #1;
      spur_en = 1'b0;
      check({tag, " starts"}, n_start - s0, v.exp_starts);
      check({tag, " out_valids"}, n_ov - o0, v.exp_starts);
      check({tag, " accepts"}, n_acc - a0, v.exp_acc);
      check({tag, " frame_done"}, n_fdone - f0, 1);
      check({tag, " windows left"}, exp_win.size(), 0);
      check({tag, " results left"}, exp_res.size(), 0);
   endtask

   task automatic check_reset(input string tag);
      @(negedge clk);
      check({tag, " in_ready"}, in_ready, 1'b0);
      check({tag, " start"}, start, 1'b0);
      check({tag, " clear"}, clear, 1'b0);
      check({tag, " out_valid"}, out_valid, 1'b0);
      check({tag, " frame_done"}, frame_done, 1'b0);
      check({tag, " out_pixel"}, out_pixel, 8'h00);
      check({tag, " window"}, window, '0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_vec_t v;
      int s0, o0, f0, t;
      n_vec       = 0;
      n_err       = 0;
      n_acc       = 0;
      n_start     = 0;
      n_ov        = 0;
      n_fdone     = 0;
      done_cyc    = -10;
      stub_dly    = 5;
      stub_res    = 8'h00;
      spur_en     = 1'b0;
      abort       = 1'b0;
      last_win    = '0;
      n_rst       = 1'b0;
      frame_start = 1'b0;
      img_width   = '0;
      img_height  = '0;
      in_valid    = 1'b0;
      in_pixel    = 8'h00;

      tbl[0] = '{w: 4, h: 4, base: 0,   toggle: 0, spur: 0, dly: 5, res: 8'hA5,
                 exp_starts: 4, exp_acc: 16};
      tbl[1] = '{w: 2, h: 5, base: 40,  toggle: 0, spur: 0, dly: 5, res: 8'h11,
                 exp_starts: 0, exp_acc: 10};
      tbl[2] = '{w: 4, h: 4, base: 0,   toggle: 1, spur: 1, dly: 3, res: 8'h3C,
                 exp_starts: 4, exp_acc: 16};
      tbl[3] = '{w: 5, h: 3, base: 100, toggle: 0, spur: 0, dly: 1, res: 8'h5A,
                 exp_starts: 3, exp_acc: 15};
      tbl[4] = '{w: 0, h: 4, base: 0,   toggle: 0, spur: 0, dly: 2, res: 8'h22,
                 exp_starts: 0, exp_acc: 0};
      tbl[5] = '{w: 3, h: 3, base: 250, toggle: 0, spur: 0, dly: 2, res: 8'hC3,
                 exp_starts: 1, exp_acc: 9};
      tbl[6] = '{w: 6, h: 4, base: 7,   toggle: 1, spur: 0, dly: 3, res: 8'h69,
                 exp_starts: 8, exp_acc: 24};

      repeat (2) @(negedge clk);
      check_reset("por");
      @(posedge clk);
      #1;
      n_rst = 1'b1;

      for (int i = 0; i < 7; i++) begin
         run_frame(tbl[i], $sformatf("vec%0d", i));
      end

      // Reset while waiting on the compute stage, then a clean 3x3 frame.
      v = '{w: 4, h: 4, base: 0, toggle: 0, spur: 0, dly: 60, res: 8'h99,
            exp_starts: 1, exp_acc: 9};
      stub_dly = v.dly;
      stub_res = v.res;
      s0 = n_start;
      fork
         drive_frame(v, "rst_wait");
         begin
            t = 0;
            while (n_start == s0 && t < 300) begin
               @(posedge clk);
               t++;
            end
            repeat (3) @(posedge clk);
            #1;
            n_rst = 1'b0;
            abort = 1'b1;
         end
      join
      check("rst_wait start before reset", n_start - s0, 1);
      check_reset("rst_wait");
      @(posedge clk);
      #1;
      exp_win.delete();
      exp_res.delete();
      n_rst = 1'b1;
      abort = 1'b0;
      s0 = n_start;
      o0 = n_ov;
      f0 = n_fdone;
      repeat (12) @(posedge clk);
      #1;
      check("post-reset starts", n_start - s0, 0);
      check("post-reset out_valids", n_ov - o0, 0);
      check("post-reset frame_done", n_fdone - f0, 0);
      v = '{w: 3, h: 3, base: 0, toggle: 0, spur: 0, dly: 4, res: 8'h77,
            exp_starts: 1, exp_acc: 9};
      run_frame(v, "after_rst");

      // frame_start (with a different size) pulsed during WAIT must be ignored.
      v = '{w: 4, h: 4, base: 20, toggle: 0, spur: 0, dly: 6, res: 8'h4B,
            exp_starts: 4, exp_acc: 16};
      s0 = n_start;
      fork
         run_frame(v, "fs_wait");
         begin
            t = 0;
            while (n_start == s0 && t < 300) begin
               @(posedge clk);
               t++;
            end
            #1;
            frame_start = 1'b1;
            img_width   = WW'(2);
            img_height  = HW'(2);
            @(posedge clk);
            #1;
            frame_start = 1'b0;
         end
      join

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/window_feeder.md
WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 Parameter MAX_KERNEL, default 3, window edge length K in pixels.
REQ-002 Parameter IMG_W_MAX, default 64, maximum image width in pixels.
REQ-003 Parameter IMG_H_MAX, default 64, maximum image height in pixels.
REQ-004 clk  input  1  clock; reset n_rst, asynchronous, active-low.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 frame_start  input  1  one-cycle pulse that begins a frame.
REQ-007 img_width  input  $clog2(IMG_W_MAX+1)  frame width, sampled on frame_start.
REQ-008 img_height  input  $clog2(IMG_H_MAX+1)  frame height, sampled on frame_start.
REQ-009 in_valid  input  1  raster-order pixel valid.
REQ-010 in_pixel  input  8  pixel data.
REQ-011 in_ready  output  1  block accepts in_pixel this cycle.
REQ-012 window  output  [K-1:0][K-1:0][7:0]  window[r][c]; r=0 is the top (oldest) row, c=0 is the leftmost column.
REQ-013 start  output  1  one-cycle request to the compute stage.
REQ-014 done  input  1  compute stage result ready.
REQ-015 result  input  8  compute stage output pixel.
REQ-016 clear  output  1  one-cycle accumulator clear.
REQ-017 out_valid  output  1  one-cycle valid for out_pixel.
REQ-018 out_pixel  output  8  registered result.
REQ-019 frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-020 FSM states SHALL be IDLE, ACCEPT, ISSUE, WAIT, CLEAR and FIN.
REQ-021 IDLE: in_ready=0; on frame_start, latch width and height, zero col/row counters, go to ACCEPT; if width or height is 0, go to FIN instead.
REQ-022 ACCEPT: in_ready=1; a pixel is accepted when in_valid and in_ready are both 1.
REQ-023 On accept, the new column SHALL be {lb[0][col], ..., lb[K-2][col], in_pixel}, ordered top to bottom.
REQ-024 On accept, window[r][c] <= window[r][c+1] for c<K-1, and window[r][K-1] <= new column entry r.
REQ-025 On accept, line buffers SHALL shift up: lb[i][col] <= lb[i+1][col] for i<K-2, and lb[K-2][col] <= in_pixel.
REQ-026 Counters: col increments per accept; at col=width-1, col wraps to 0 and row increments.
REQ-027 An accept with row>=K-1 and col>=K-1 completes a window: next state ISSUE.
REQ-028 Otherwise, an accept of the last pixel (row=height-1, col=width-1) goes to FIN; any other accept stays in ACCEPT.
REQ-029 ISSUE: start=1 for exactly one cycle, then go to WAIT.
REQ-030 WAIT: start=0, in_ready=0, window held stable; done is the only exit.
REQ-031 On done in WAIT: out_pixel <= result; next cycle out_valid=1 and clear=1 (state CLEAR).
REQ-032 CLEAR lasts one cycle: go to FIN if the completing pixel was the frame's last, otherwise go to ACCEPT.
REQ-033 FIN: frame_done=1 for one cycle, then go to IDLE.
REQ-034 Latency: accept at cycle t gives start at t+1; done at cycle d gives out_valid/clear at d+1; next accept no earlier than d+2.
REQ-035 Window count per frame SHALL be (W-K+1)*(H-K+1) when W>=K and H>=K, else 0; no padding.
REQ-036 frame_start outside IDLE SHALL be ignored.
REQ-037 done outside WAIT SHALL be ignored.
REQ-038 Stale columns from the previous row SHALL never appear in an issued window.
REQ-039 Width/height inputs changing mid-frame SHALL have no effect.

Reset
REQ-040 On n_rst low: state IDLE; in_ready, start, clear, out_valid, frame_done = 0; out_pixel = 0; window = 0; counters = 0.
REQ-041 Line-buffer contents need no reset.
REQ-042 Reset mid-frame SHALL abandon the frame; no pulse may be emitted after reset is released.

Verification
REQ-043 4x4 frame of pixels 0..15, done stub returning 5 cycles after start -> first window rows {0,1,2;4,5,6;8,9,10}, second {1,2,3;5,6,7;9,10,11}, 4 starts, then frame_done.
REQ-044 Stub result=0xA5 -> out_pixel=0xA5, with out_valid and clear both high for exactly the cycle after done.
REQ-045 2x5 frame -> zero starts, in_ready high for 10 accepts, frame_done once.
REQ-046 in_valid toggling every cycle, plus spurious done in ACCEPT -> identical windows, no extra out_valid.
REQ-047 n_rst asserted in WAIT of a 4x4 frame, then a new 3x3 frame -> exactly 1 start with window {0,1,2;3,4,5;6,7,8}.
REQ-048 frame_start pulse during WAIT -> ignored; window count unchanged.
